// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings,
// opcode bit positions, FSM state type and the request legality check.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Op[2] selects zero-extension for sub-word loads.
    localparam int OP_UNSIGNED_BIT = 2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } lsu_state_t;

    // A request is illegal when misaligned for its size, uses the reserved
    // size, or names a word beyond the end of the memory.
    function automatic logic req_error(input logic [31:0] addr,
                                       input logic [1:0]  size,
                                       input logic [31:0] mem_words);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr[0];
            SZ_WORD: bad = (addr[1:0] != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad | ({2'b00, addr[31:2]} >= mem_words);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit: extracts and extends the
// addressed byte/half for loads, and merges store data into a memory word
// for read-modify-write stores. Purely combinational, little-endian lanes.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] mem_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // Pick the addressed byte and half out of the memory word.
    always_comb begin
        lane_byte = 8'h00;
        lane_half = 16'h0000;
        case (addr_lo)
            2'b00:   lane_byte = mem_word[7:0];
            2'b01:   lane_byte = mem_word[15:8];
            2'b10:   lane_byte = mem_word[23:16];
            2'b11:   lane_byte = mem_word[31:24];
            default: lane_byte = 8'h00;
        endcase
        if (addr_lo[1]) begin
            lane_half = mem_word[31:16];
        end else begin
            lane_half = mem_word[15:0];
        end
    end

    // Sign- or zero-extend the selected lane to a full load result.
    always_comb begin
        load_data = 32'h0000_0000;
        case (size)
            SZ_BYTE: begin
                if (is_unsigned) begin
                    load_data = {24'h00_0000, lane_byte};
                end else begin
                    load_data = {{24{lane_byte[7]}}, lane_byte};
                end
            end
            SZ_HALF: begin
                if (is_unsigned) begin
                    load_data = {16'h0000, lane_half};
                end else begin
                    load_data = {{16{lane_half[15]}}, lane_half};
                end
            end
            SZ_WORD: load_data = mem_word;
            default: load_data = 32'h0000_0000;
        endcase
    end

    // Replace the target lane(s) of the old word with the store data.
    always_comb begin
        merge_data = mem_word;
        case (size)
            SZ_BYTE: begin
                case (addr_lo)
                    2'b00:   merge_data[7:0]   = store_data[7:0];
                    2'b01:   merge_data[15:8]  = store_data[7:0];
                    2'b10:   merge_data[23:16] = store_data[7:0];
                    2'b11:   merge_data[31:24] = store_data[7:0];
                    default: merge_data        = mem_word;
                endcase
            end
            SZ_HALF: begin
                if (addr_lo[1]) begin
                    merge_data[31:16] = store_data[15:0];
                end else begin
                    merge_data[15:0]  = store_data[15:0];
                end
            end
            default: merge_data = store_data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: converts byte-addressed LB/LBU/LH/LHU/LW and
// SB/SH/SW requests into word accesses on a single-port data memory. Sub-word
// stores are done as read-modify-write; illegal requests complete with Err.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 256
)
(
    input  logic        clk,
    input  logic        rstbar,
    input  logic        Req,
    output logic        Ready,
    input  logic        IsStore,
    input  logic [2:0]  Op,
    input  logic [31:0] Addr,
    input  logic [31:0] WData,
    output logic [31:0] RData,
    output logic        Done,
    output logic        Err,
    output logic [31:0] MemAddress,
    output logic        MemRbarW,
    output logic [31:0] MemWriteData,
    input  logic [31:0] MemReadData
);

    lsu_state_t  state;
    lsu_state_t  state_next;
    logic        accept;
    logic        req_bad;
    logic [1:0]  req_addr_lo;
    logic [2:0]  req_op;
    logic        req_store;
    logic [31:0] req_wdata;
    logic [31:0] rd_buf;
    logic [31:0] align_word;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    assign accept  = Req && (state == IDLE);
    assign req_bad = req_error(Addr, Op[1:0], 32'(MEM_WORDS));

    // In RD the word comes straight from the memory so the load result and
    // the merged store word are ready on the same edge that fills rd_buf.
    assign align_word = (state == RD) ? MemReadData : rd_buf;

    lsu_align u_align (
        .addr_lo     (req_addr_lo),
        .size        (req_op[1:0]),
        .is_unsigned (req_op[OP_UNSIGNED_BIT]),
        .mem_word    (align_word),
        .store_data  (req_wdata),
        .load_data   (load_data),
        .merge_data  (merge_data)
    );

    // FSM state register; reset abandons any request in flight.
    always_ff @(posedge clk or negedge rstbar) begin
        if (!rstbar) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: errors finish at once, SW skips the read phase.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (Req) begin
                    if (req_bad) begin
                        state_next = ERR;
                    end else if (IsStore && (Op[1:0] == SZ_WORD)) begin
                        state_next = WR;
                    end else begin
                        state_next = RD;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            RD: begin
                if (req_store) begin
                    state_next = WR;
                end else begin
                    state_next = DONE;
                end
            end
            WR:      state_next = DONE;
            DONE:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request latches, memory-port registers and registered status outputs.
    always_ff @(posedge clk or negedge rstbar) begin
        if (!rstbar) begin
            Ready        <= 1'b1;
            Done         <= 1'b0;
            Err          <= 1'b0;
            RData        <= 32'h0000_0000;
            MemAddress   <= 32'h0000_0000;
            MemRbarW     <= 1'b0;
            MemWriteData <= 32'h0000_0000;
            rd_buf       <= 32'h0000_0000;
            req_addr_lo  <= 2'b00;
            req_op       <= 3'b000;
            req_store    <= 1'b0;
            req_wdata    <= 32'h0000_0000;
        end else begin
            Ready    <= (state_next == IDLE);
            Done     <= (state_next == DONE) || (state_next == ERR);
            Err      <= (state_next == ERR);
            MemRbarW <= (state_next == WR);
            if (accept) begin
                req_addr_lo <= Addr[1:0];
                req_op      <= Op;
                req_store   <= IsStore;
                req_wdata   <= WData;
                MemAddress  <= {2'b00, Addr[31:2]};
                if (IsStore && !req_bad) begin
                    MemWriteData <= WData;
                end
            end
            if (state == RD) begin
                rd_buf <= MemReadData;
                if (req_store) begin
                    MemWriteData <= merge_data;
                end else begin
                    RData <= load_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a word memory answering the DUT
// port, plus a byte-arithmetic reference model of memory contents and results.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rstbar;
    logic        Req;
    logic        Ready;
    logic        IsStore;
    logic [2:0]  Op;
    logic [31:0] Addr;
    logic [31:0] WData;
    logic [31:0] RData;
    logic        Done;
    logic        Err;
    logic [31:0] MemAddress;
    logic        MemRbarW;
    logic [31:0] MemWriteData;
    logic [31:0] MemReadData;

    load_store_unit #(.MEM_WORDS(256)) dut (
        .clk(clk), .rstbar(rstbar), .Req(Req), .Ready(Ready), .IsStore(IsStore),
        .Op(Op), .Addr(Addr), .WData(WData), .RData(RData), .Done(Done), .Err(Err),
        .MemAddress(MemAddress), .MemRbarW(MemRbarW), .MemWriteData(MemWriteData),
        .MemReadData(MemReadData)
    );

    always #5 clk = ~clk;

    // Data memory behind the port
    logic [31:0] mem [0:255];
    assign MemReadData = (MemAddress < 32'd256) ? mem[MemAddress[7:0]] : 32'h0;
    always @(posedge clk) begin
        if (MemRbarW && (MemAddress < 32'd256)) mem[MemAddress[7:0]] <= MemWriteData;
    end

    // Reference model state
    logic [31:0] ref_mem [0:255];
    logic [31:0] ref_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    // Observations of one transaction
    int          t_done_cyc;
    int          t_wr_cyc;
    logic        t_err;
    logic        t_wr_seen;
    logic [31:0] t_rdata;
    logic [31:0] t_wr_addr;
    logic [31:0] t_wr_data;

    typedef struct {
        logic        st;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] wd;
        logic        has_lit;
        logic [31:0] lit;
    } op_t;

    // Reference model: apply one request with plain byte arithmetic.
    task automatic model_op(input logic st, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] wd, output logic e_err, output int e_cyc,
                            output logic e_wr, output logic [31:0] e_wdata);
        int unsigned bytes, off, idx;
        longint unsigned mask, word, v;
        bytes = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : (op[1:0] == 2'd2) ? 4 : 0;
        off = a % 4;
        idx = a / 4;
        e_wr = 1'b0;
        e_wdata = 32'h0;
        if (bytes == 0) e_err = 1'b1;
        else e_err = (idx >= 256) || ((off % bytes) != 0);
        if (e_err) begin
            e_cyc = 1;
            return;
        end
        mask = (64'd1 << (8 * bytes)) - 64'd1;
        word = longint'(ref_mem[idx]);
        if (!st) begin
            v = (word >> (8 * off)) & mask;
            if (!op[2] && bytes < 4 && ((v >> (8 * bytes - 1)) & 64'd1) == 64'd1)
                v = v | (64'hFFFF_FFFF & ~mask);
            ref_rdata = 32'(v);
            e_cyc = 2;
        end else begin
            v = (word & ~(mask << (8 * off))) | ((longint'(wd) & mask) << (8 * off));
            e_wdata = 32'(v);
            ref_mem[idx] = e_wdata;
            e_wr = 1'b1;
            e_cyc = (bytes == 4) ? 2 : 3;
        end
    endtask

    // Issue one request from IDLE and observe it until Done (bounded).
    task automatic do_op(input logic st, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] wd);
        IsStore = st; Op = op; Addr = a; WData = wd; Req = 1'b1;
        @(posedge clk); #1;
        Req = 1'b0;
        t_done_cyc = 0; t_wr_cyc = 0; t_err = 1'b0; t_wr_seen = 1'b0;
        t_rdata = 32'h0; t_wr_addr = 32'h0; t_wr_data = 32'h0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (MemRbarW) begin
                t_wr_seen = 1'b1; t_wr_cyc = c; t_wr_addr = MemAddress; t_wr_data = MemWriteData;
            end
            if (Done) begin
                t_done_cyc = c; t_err = Err; t_rdata = RData;
                break;
            end
            @(posedge clk);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rstbar = 1'b0; Req = 1'b0; IsStore = 1'b0; Op = 3'b000; Addr = 32'h0; WData = 32'h0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'(i);
            ref_mem[i] = 32'(i);
        end
        ref_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({Ready, Done, Err, MemRbarW, RData, MemAddress, MemWriteData} !== {4'b1000, 96'h0})
            $display("FAIL reset_in: got %h expected %h",
                     {Ready, Done, Err, MemRbarW, RData, MemAddress, MemWriteData}, {4'b1000, 96'h0});
        else n_pass++;
        @(negedge clk); rstbar = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({Ready, Done, Err, MemRbarW} !== 4'b1000)
            $display("FAIL reset_after: got %b expected 1000", {Ready, Done, Err, MemRbarW});
        else n_pass++;
    endtask

    task automatic test_plan();
        op_t         tbl [10];
        logic        e_err, e_wr;
        int          e_cyc;
        logic [31:0] e_wdata;
        tbl[0] = '{1'b0, 3'b010, 32'h14,  32'h0,        1'b1, 32'h0000_0005};
        tbl[1] = '{1'b1, 3'b010, 32'h80,  32'hDEADBEEF, 1'b1, 32'hDEADBEEF};
        tbl[2] = '{1'b0, 3'b000, 32'h83,  32'h0,        1'b1, 32'hFFFF_FFDE};
        tbl[3] = '{1'b0, 3'b100, 32'h83,  32'h0,        1'b1, 32'h0000_00DE};
        tbl[4] = '{1'b0, 3'b001, 32'h82,  32'h0,        1'b1, 32'hFFFF_DEAD};
        tbl[5] = '{1'b1, 3'b000, 32'h81,  32'h11,       1'b1, 32'hDEAD_11EF};
        tbl[6] = '{1'b0, 3'b010, 32'h80,  32'h0,        1'b1, 32'hDEAD_11EF};
        tbl[7] = '{1'b0, 3'b001, 32'h81,  32'h0,        1'b1, 32'hDEAD_11EF};
        tbl[8] = '{1'b0, 3'b010, 32'h82,  32'h0,        1'b1, 32'hDEAD_11EF};
        tbl[9] = '{1'b0, 3'b010, 32'h400, 32'h0,        1'b1, 32'hDEAD_11EF};
        for (int i = 0; i < 10; i++) begin
            model_op(tbl[i].st, tbl[i].op, tbl[i].a, tbl[i].wd, e_err, e_cyc, e_wr, e_wdata);
            do_op(tbl[i].st, tbl[i].op, tbl[i].a, tbl[i].wd);
            n_checks++;
            if (t_done_cyc !== e_cyc) $display("FAIL plan%0d done_cycle: got %0d expected %0d", i, t_done_cyc, e_cyc);
            else n_pass++;
            n_checks++;
            if (t_err !== e_err) $display("FAIL plan%0d err: got %b expected %b", i, t_err, e_err);
            else n_pass++;
            n_checks++;
            if (t_rdata !== ref_rdata) $display("FAIL plan%0d rdata: got %h expected %h", i, t_rdata, ref_rdata);
            else n_pass++;
            n_checks++;
            if (t_wr_seen !== e_wr) $display("FAIL plan%0d write_seen: got %b expected %b", i, t_wr_seen, e_wr);
            else n_pass++;
            if (e_wr) begin
                n_checks++;
                if ({t_wr_addr, t_wr_data} !== {tbl[i].a >> 2, e_wdata})
                    $display("FAIL plan%0d write: got addr %h data %h expected addr %h data %h",
                             i, t_wr_addr, t_wr_data, tbl[i].a >> 2, e_wdata);
                else n_pass++;
                n_checks++;
                if (t_wr_cyc !== e_cyc - 1) $display("FAIL plan%0d write_cycle: got %0d expected %0d", i, t_wr_cyc, e_cyc - 1);
                else n_pass++;
            end
            n_checks++;
            if ((tbl[i].st ? t_wr_data : t_rdata) !== tbl[i].lit)
                $display("FAIL plan%0d literal: got %h expected %h", i, tbl[i].st ? t_wr_data : t_rdata, tbl[i].lit);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic        cur_st, e_err, e_wr, pending;
        logic [2:0]  cur_op;
        logic [31:0] cur_a, cur_wd, e_wdata;
        int          e_cyc, acc_cyc, accepts, dones, k;
        pending = 1'b0; accepts = 0; dones = 0; k = 0; acc_cyc = 0; e_cyc = 0;
        cur_st = 1'b1; cur_op = 3'b001; cur_a = 32'h100; cur_wd = $urandom;
        IsStore = cur_st; Op = cur_op; Addr = cur_a; WData = cur_wd; Req = 1'b1;
        for (int cyc = 0; cyc < 80; cyc++) begin
            @(negedge clk);
            if (Done) begin
                dones++;
                n_checks++;
                if (!pending || (cyc - acc_cyc) != e_cyc || Err !== 1'b0)
                    $display("FAIL b2b done: cycle %0d after accept got pending %b err %b expected latency %0d",
                             cyc - acc_cyc, pending, Err, e_cyc);
                else n_pass++;
                if (!cur_st) begin
                    n_checks++;
                    if (RData !== ref_rdata) $display("FAIL b2b rdata: got %h expected %h", RData, ref_rdata);
                    else n_pass++;
                end
                pending = 1'b0;
                if (accepts >= 10) break;
            end
            if (Ready && Req) begin
                n_checks++;
                if (pending) $display("FAIL b2b ready_busy: got Ready 1 expected 0 at cycle %0d", cyc);
                else n_pass++;
                model_op(cur_st, cur_op, cur_a, cur_wd, e_err, e_cyc, e_wr, e_wdata);
                pending = 1'b1; acc_cyc = cyc; accepts++;
                @(posedge clk); #1;
                k++;
                cur_st = ~k[0]; cur_op = k[0] ? 3'b010 : 3'b001;
                cur_a = k[0] ? 32'h100 : (32'h100 + 32'(2 * (k % 4 / 2)));
                cur_wd = $urandom;
                IsStore = cur_st; Op = cur_op; Addr = cur_a; WData = cur_wd;
                if (accepts >= 10) Req = 1'b0;
            end else begin
                @(posedge clk);
            end
        end
        Req = 1'b0;
        n_checks++;
        if (dones !== 10) $display("FAIL b2b done_count: got %0d expected 10", dones);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_op();
        int wr_high;
        // SH to 0x84 interrupted during RD
        IsStore = 1'b1; Op = 3'b001; Addr = 32'h84; WData = 32'h0000_BEEF; Req = 1'b1;
        @(posedge clk); #1; Req = 1'b0;
        @(negedge clk);
        rstbar = 1'b0; #1;
        n_checks++;
        if ({Ready, Done, Err, MemRbarW, RData, MemAddress, MemWriteData} !== {4'b1000, 96'h0})
            $display("FAIL rst_rd outputs: got %h expected %h",
                     {Ready, Done, Err, MemRbarW, RData, MemAddress, MemWriteData}, {4'b1000, 96'h0});
        else n_pass++;
        wr_high = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 1) rstbar = 1'b1;
            if (MemRbarW || Done) wr_high++;
        end
        n_checks++;
        if (wr_high !== 0) $display("FAIL rst_rd quiet: got %0d write/done samples expected 0", wr_high);
        else n_pass++;
        ref_rdata = 32'h0;
        @(posedge clk); #1;
        // SW interrupted during WR: data equals current contents either way
        IsStore = 1'b1; Op = 3'b010; Addr = 32'h88; WData = ref_mem[34]; Req = 1'b1;
        @(posedge clk); #1; Req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (MemRbarW !== 1'b1) $display("FAIL rst_wr in_wr: got %b expected 1", MemRbarW);
        else n_pass++;
        rstbar = 1'b0; #1;
        n_checks++;
        if (MemRbarW !== 1'b0) $display("FAIL rst_wr drop: got %b expected 0", MemRbarW);
        else n_pass++;
        @(negedge clk); rstbar = 1'b1;
        @(posedge clk); #1;
        do_op(1'b0, 3'b010, 32'h84, 32'h0);
        n_checks++;
        if ({t_done_cyc, t_err, t_rdata} !== {32'd2, 1'b0, 32'h0000_0021})
            $display("FAIL rst_lw_after: got cyc %0d err %b data %h expected cyc 2 err 0 data 00000021",
                     t_done_cyc, t_err, t_rdata);
        else n_pass++;
        ref_rdata = 32'h0000_0021;
    endtask

    task automatic test_random();
        logic        st, e_err, e_wr;
        logic [2:0]  op;
        logic [31:0] a, wd, e_wdata;
        int          e_cyc;
        for (int i = 0; i < 80; i++) begin
            st = 1'($urandom_range(0, 1));
            op = 3'($urandom_range(0, 7));
            a  = $urandom_range(0, 32'h43F);
            wd = $urandom;
            model_op(st, op, a, wd, e_err, e_cyc, e_wr, e_wdata);
            do_op(st, op, a, wd);
            n_checks++;
            if ({t_done_cyc, t_err} !== {e_cyc, e_err})
                $display("FAIL rand%0d done: got cyc %0d err %b expected cyc %0d err %b (st %b op %b a %h)",
                         i, t_done_cyc, t_err, e_cyc, e_err, st, op, a);
            else n_pass++;
            n_checks++;
            if (t_rdata !== ref_rdata) $display("FAIL rand%0d rdata: got %h expected %h (op %b a %h)", i, t_rdata, ref_rdata, op, a);
            else n_pass++;
            n_checks++;
            if ({t_wr_seen, t_wr_data} !== {e_wr, e_wdata} || (e_wr && t_wr_addr !== (a >> 2)))
                $display("FAIL rand%0d write: got seen %b addr %h data %h expected seen %b addr %h data %h",
                         i, t_wr_seen, t_wr_addr, t_wr_data, e_wr, a >> 2, e_wdata);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_plan();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit sitting directly upstream of the data memory in the 32-bit MIPS datapath. Takes byte-addressed load/store requests (LB, LBU, LH, LHU, LW, SB, SH, SW) from the pipeline and turns them into word-granular accesses on the data memory port (word address, `rbar_w`, write data, read data). Sub-word loads are extracted and sign- or zero-extended. Sub-word stores use a read-modify-write sequence.

## Interface
- `MEM_WORDS`, 256: number of 32-bit words behind the memory port. A word index `>= MEM_WORDS` is out of range.
- `clk` input 1: single clock, rising edge.
- `rstbar` input 1: reset; asynchronous, active-low.
- `Req` input 1: request valid; accepted on a rising edge when `Req & Ready`.
- `Ready` output 1: high only in IDLE.
- `IsStore` input 1: 1 = store, 0 = load.
- `Op` input 3: bit 2 = unsigned (loads only); bits [1:0] = size (00 byte, 01 half, 10 word, 11 reserved and treated as an error).
- `Addr` input 32: byte address.
- `WData` input 32: store data, right-justified.
- `RData` output 32: extended load result; holds until the next load completes.
- `Done` output 1: one-cycle completion pulse.
- `Err` output 1: valid with `Done`; misaligned, out-of-range or reserved size.
- `MemAddress` output 32: word index, equal to `Addr[31:2]` zero-extended.
- `MemRbarW` output 1: 1 = write, 0 = read.
- `MemWriteData` output 32: word to write.
- `MemReadData` input 32: combinational read data from the memory.

## Operation
- Byte lanes are little-endian. Byte `n` = bits `[8n+7:8n]`; a half at `Addr[1]` = bits `[16*Addr[1]+15 : 16*Addr[1]]`.
- On accept, latch `Addr`, `WData`, `Op` and `IsStore`, then check the request:
  - Error if a half access has `Addr[0]=1`.
  - Error if a word access has `Addr[1:0]!=0`.
  - Error if size = 11.
  - Error if `Addr[31:2] >= MEM_WORDS`.
- State machine, registered states:
  - IDLE: `Ready=1`. On accept: error → ERR; load or SB/SH → RD; SW → WR.
  - RD: drive `MemAddress`, `MemRbarW=0`. At the edge, capture `MemReadData` into `RdBuf`. Load → DONE; SB/SH → WR.
  - WR: drive `MemAddress`, `MemRbarW=1`. `MemWriteData` is `WData` for SW, or `RdBuf` with the target lane(s) replaced by `WData[7:0]`/`WData[15:0]` for SB/SH. Next state DONE.
  - DONE: `Done=1`, `Err=0`. For loads, `RData` is updated from `RdBuf` on entry. Next state IDLE.
  - ERR: `Done=1`, `Err=1`. `RData` is unchanged and no memory write occurs. Next state IDLE.
- `MemRbarW` is 1 only in WR. `MemAddress` and `MemWriteData` are registered and stable for the whole of WR.
- Loads extend per `Op[2]`: 0 = sign-extend, 1 = zero-extend. LW ignores `Op[2]`.
- For stores, `Op[2]` is ignored.
- `Req` is ignored while `Ready=0`. There is no queueing.

## Timing
- Accept edge = E0.
- Load: RD in cycle 1, `Done` in cycle 2.
- SW: WR in cycle 1, `Done` in cycle 2.
- SB/SH: RD, then WR, then `Done` in cycle 3.
- Error: `Done`/`Err` in cycle 1.
- After `Done`, the unit is back in IDLE and can accept on the next edge.
- Reset values: state IDLE, `Ready=1`, `Done=0`, `Err=0`, `RData=0`, `MemAddress=0`, `MemRbarW=0`, `MemWriteData=0`, `RdBuf=0`.
- Reset asserted mid-operation: the FSM returns to IDLE asynchronously and `MemRbarW` drops to 0 immediately.
  - Reset during RD of an SB/SH: no write occurs.
  - Reset during WR: the write may or may not have landed; software does not rely on it.
  - `Done` does not pulse for the abandoned request.

## Structure
- `lsu_pkg` holds:
  - size encodings `SZ_BYTE=2'b00`, `SZ_HALF=2'b01`, `SZ_WORD=2'b10`;
  - the unsigned bit index (2);
  - the FSM state enum (IDLE, RD, WR, DONE, ERR).
- One combinational sub-module, `lsu_align`. It performs lane extraction with extension (load path) and lane merge (store path), driven by `Addr[1:0]`, size and unsigned. The FSM stays in `load_store_unit`.

## Test plan
The data memory powers up with `Mem[i]=i`.
- LW `0x14` after reset → `Done` in cycle 2, `RData=0x00000005`, `Err=0`, `MemRbarW` never 1.
- SW `0x80` with `0xDEADBEEF` → WR in cycle 1 at `MemAddress=32`. Then:
  - LB `0x83` → `0xFFFFFFDE`;
  - LBU `0x83` → `0x000000DE`;
  - LH `0x82` → `0xFFFFDEAD`.
- SB `0x81` with `WData=0x00000011` → RD then WR, `MemWriteData=0xDEAD11EF`, `Done` in cycle 3. Then LW `0x80` → `0xDEAD11EF`.
- LH `0x81`, LW `0x82` and LW `0x400` (word 256) → each gives `Done` and `Err` in cycle 1, no RD/WR states, `RData` unchanged.
- `Req` held high continuously with alternating SH/LW → one accept per IDLE visit, no request taken while `Ready=0`.
- Assert `rstbar` low during the RD cycle of an SH to `0x84` → `MemRbarW` stays 0, outputs at reset values, and a later LW `0x84` → `0x00000021`.
